multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if #(
   parameter int unsigned ALUOP_W = 4,
   parameter int unsigned OPC_W   = 6
);
   logic [OPC_W-1:0]   opcode;
   logic [4:0]         branch_type;
   logic               mem_ready;
   logic               pc_write;
   logic               ir_write;
   logic               iord;
   logic               memread;
   logic               memwrite;
   logic               memtoreg;
   logic               regdst;
   logic               regwrite;
   logic               alusrc_a;
   logic               branch;
   logic               jump;
   logic               link;
   logic               instr_done;
   logic [1:0]         alusrc_b;
   logic [ALUOP_W-1:0] aluop;
   logic [2:0]         state;

   modport master (
      input  opcode, branch_type, mem_ready,
      output pc_write, ir_write, iord, memread, memwrite, memtoreg, regdst,
             regwrite, alusrc_a, branch, jump, link, instr_done,
             alusrc_b, aluop, state
   );

   modport slave (
      output opcode, branch_type, mem_ready,
      input  pc_write, ir_write, iord, memread, memwrite, memtoreg, regdst,
             regwrite, alusrc_a, branch, jump, link, instr_done,
             alusrc_b, aluop, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait handshake.
// Strobes are decoded from state plus the opcode latched in DECODE (live opcode while in DECODE).
module multicycle_control #(
   parameter int unsigned ALUOP_W = 4,
   parameter int unsigned OPC_W   = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_control_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [OPC_W-1:0] OP_RTYPE  = OPC_W'(6'b000000);
   localparam logic [OPC_W-1:0] OP_REGIMM = OPC_W'(6'b000001);
   localparam logic [OPC_W-1:0] OP_J      = OPC_W'(6'b000010);
   localparam logic [OPC_W-1:0] OP_JAL    = OPC_W'(6'b000011);
   localparam logic [OPC_W-1:0] OP_BEQ    = OPC_W'(6'b000100);
   localparam logic [OPC_W-1:0] OP_BNE    = OPC_W'(6'b000101);
   localparam logic [OPC_W-1:0] OP_ADDIU  = OPC_W'(6'b001001);
   localparam logic [OPC_W-1:0] OP_LW     = OPC_W'(6'b100011);
   localparam logic [OPC_W-1:0] OP_SW     = OPC_W'(6'b101011);

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;
   localparam logic [1:0] ALU_CMPZ  = 2'd3;

   state_t           r_state;
   logic [OPC_W-1:0] r_opc;
   logic [4:0]       r_bt;
   logic             r_done;

   state_t     w_next;
   logic       w_pc_write, w_ir_write, w_iord, w_memread, w_memwrite;
   logic       w_memtoreg, w_regdst, w_regwrite, w_alusrc_a, w_branch;
   logic       w_jump, w_link;
   logic [1:0] w_alusrc_b;
   logic [1:0] w_aluop;
   logic       w_live_exec;
   logic       w_bt_legal;
   logic       w_into_fetch;

   assign w_live_exec = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_ADDIU) ||
                        (bus.opcode == OP_LW)    || (bus.opcode == OP_SW)    ||
                        (bus.opcode == OP_BEQ)   || (bus.opcode == OP_BNE)   ||
                        (bus.opcode == OP_REGIMM);

   assign w_bt_legal = (r_bt == 5'b00000) || (r_bt == 5'b00001) ||
                       (r_bt == 5'b10000) || (r_bt == 5'b10001);

   // Next state and raw strobes; illegal state codes fall through to all-zero and FETCH.
   always_comb begin
      w_next     = S_FETCH;
      w_pc_write = 1'b0;
      w_ir_write = 1'b0;
      w_iord     = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_memtoreg = 1'b0;
      w_regdst   = 1'b0;
      w_regwrite = 1'b0;
      w_alusrc_a = 1'b0;
      w_branch   = 1'b0;
      w_jump     = 1'b0;
      w_link     = 1'b0;
      w_alusrc_b = 2'b00;
      w_aluop    = ALU_ADD;
      case (r_state)
         S_FETCH: begin
            w_memread  = 1'b1;
            w_alusrc_b = 2'b01;
            if (bus.mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_DECODE;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_DECODE: begin
            if (bus.opcode == OP_J) begin
               w_jump     = 1'b1;
               w_pc_write = 1'b1;
            end else if (bus.opcode == OP_JAL) begin
               w_jump     = 1'b1;
               w_pc_write = 1'b1;
               w_link     = 1'b1;
               w_regwrite = 1'b1;
            end else if (w_live_exec) begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_opc == OP_RTYPE) begin
               w_alusrc_a = 1'b1;
               w_aluop    = ALU_FUNCT;
               w_next     = S_WB;
            end else if ((r_opc == OP_ADDIU) || (r_opc == OP_LW) || (r_opc == OP_SW)) begin
               w_alusrc_a = 1'b1;
               w_alusrc_b = 2'b10;
               w_next     = (r_opc == OP_ADDIU) ? S_WB : S_MEM;
            end else if ((r_opc == OP_BEQ) || (r_opc == OP_BNE)) begin
               w_alusrc_a = 1'b1;
               w_aluop    = ALU_SUB;
               w_branch   = 1'b1;
            end else if (r_opc == OP_REGIMM) begin
               w_alusrc_a = 1'b1;
               w_aluop    = ALU_CMPZ;
               w_branch   = w_bt_legal;
               w_link     = w_bt_legal & r_bt[4];
               w_regwrite = w_bt_legal & r_bt[4];
            end
         end
         S_MEM: begin
            w_iord     = 1'b1;
            w_memread  = (r_opc == OP_LW);
            w_memwrite = (r_opc == OP_SW);
            if (!bus.mem_ready)         w_next = S_MEM;
            else if (r_opc == OP_LW)    w_next = S_WB;
            else                        w_next = S_FETCH;
         end
         S_WB: begin
            w_regwrite = 1'b1;
            w_regdst   = (r_opc == OP_RTYPE);
            w_memtoreg = (r_opc == OP_LW);
         end
         default: w_next = S_FETCH;
      endcase
   end

   assign w_into_fetch = (w_next == S_FETCH) &&
                         ((r_state == S_DECODE) || (r_state == S_EXEC) ||
                          (r_state == S_MEM)    || (r_state == S_WB));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_opc   <= '0;
         r_bt    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_into_fetch;
         if (r_state == S_DECODE) begin
            r_opc <= bus.opcode;
            r_bt  <= bus.branch_type;
         end
      end
   end

   // Reset gates every strobe directly so an aborted instruction cannot emit a write.
   assign bus.pc_write   = rst_n & w_pc_write;
   assign bus.ir_write   = rst_n & w_ir_write;
   assign bus.iord       = rst_n & w_iord;
   assign bus.memread    = rst_n & w_memread;
   assign bus.memwrite   = rst_n & w_memwrite;
   assign bus.memtoreg   = rst_n & w_memtoreg;
   assign bus.regdst     = rst_n & w_regdst;
   assign bus.regwrite   = rst_n & w_regwrite;
   assign bus.alusrc_a   = rst_n & w_alusrc_a;
   assign bus.branch     = rst_n & w_branch;
   assign bus.jump       = rst_n & w_jump;
   assign bus.link       = rst_n & w_link;
   assign bus.instr_done = rst_n & r_done;
   assign bus.alusrc_b   = rst_n ? w_alusrc_b : 2'b00;
   assign bus.aluop      = rst_n ? ALUOP_W'(w_aluop) : '0;
   assign bus.state      = 3'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: per-instruction expected cycle traces built from the control rules, compared every cycle.
module tb_multicycle_control;

   localparam int unsigned ALUOP_W = 4;
   localparam int unsigned OPC_W   = 6;

   localparam logic [12:0] PCW  = 13'h1000;
   localparam logic [12:0] IRW  = 13'h0800;
   localparam logic [12:0] IORD = 13'h0400;
   localparam logic [12:0] MRD  = 13'h0200;
   localparam logic [12:0] MWR  = 13'h0100;
   localparam logic [12:0] MTR  = 13'h0080;
   localparam logic [12:0] RDST = 13'h0040;
   localparam logic [12:0] RW   = 13'h0020;
   localparam logic [12:0] ASA  = 13'h0010;
   localparam logic [12:0] BR   = 13'h0008;
   localparam logic [12:0] JMP  = 13'h0004;
   localparam logic [12:0] LNK  = 13'h0002;
   localparam logic [12:0] DONE = 13'h0001;

   typedef struct packed {
      logic [2:0]  st;
      logic [12:0] c;
      logic [1:0]  b;
      logic [1:0]  op;
      logic        rdy;
   } cyc_t;

   logic  clk = 1'b0;
   logic  rst_n;
   int    total = 0;
   int    bad   = 0;
   cyc_t  trace[$];
   cyc_t  exp_c;
   bit    exp_v;
   bit    first_done;
   string cur;

   always #5 clk = ~clk;

   multicycle_control_if #(.ALUOP_W(ALUOP_W), .OPC_W(OPC_W)) bus ();

   multicycle_control #(.ALUOP_W(ALUOP_W), .OPC_W(OPC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic cyc_t mk(input logic [2:0] st, input logic [12:0] c,
                               input logic [1:0] b, input logic [1:0] op, input logic rdy);
      cyc_t r;
      r.st = st; r.c = c; r.b = b; r.op = op; r.rdy = rdy;
      return r;
   endfunction

   function automatic logic [12:0] ctrl_vec();
      return {bus.pc_write, bus.ir_write, bus.iord, bus.memread, bus.memwrite,
              bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrc_a, bus.branch,
              bus.jump, bus.link, bus.instr_done};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s [%s] t=%0t: got 0x%0h expected 0x%0h", nm, cur, $time, got, want);
      end
   endtask

   // Expected cycle-by-cycle behaviour of one instruction, from FETCH until the return to FETCH.
   task automatic build(input logic [5:0] opc, input logic [4:0] bt, input int wf, input int wm,
                        input bit done0);
      logic [12:0] d;
      logic [12:0] c;
      bit is_lw, is_sw, is_r, is_addiu, is_br, is_ri, legal;
      trace.delete();
      d = done0 ? DONE : 13'h0;
      for (int i = 0; i < wf; i++) begin
         trace.push_back(mk(3'd0, MRD | d, 2'b01, 2'd0, 1'b0));
         d = 13'h0;
      end
      trace.push_back(mk(3'd0, MRD | IRW | PCW | d, 2'b01, 2'd0, 1'b1));
      if (opc == 6'b000010) begin
         trace.push_back(mk(3'd1, JMP | PCW, 2'b00, 2'd0, 1'b1));
         return;
      end
      if (opc == 6'b000011) begin
         trace.push_back(mk(3'd1, JMP | PCW | LNK | RW, 2'b00, 2'd0, 1'b1));
         return;
      end
      is_r     = (opc == 6'b000000);
      is_addiu = (opc == 6'b001001);
      is_lw    = (opc == 6'b100011);
      is_sw    = (opc == 6'b101011);
      is_br    = (opc == 6'b000100) || (opc == 6'b000101);
      is_ri    = (opc == 6'b000001);
      trace.push_back(mk(3'd1, 13'h0, 2'b00, 2'd0, 1'b1));
      if (!(is_r || is_addiu || is_lw || is_sw || is_br || is_ri)) return;
      if (is_r) begin
         trace.push_back(mk(3'd2, ASA, 2'b00, 2'd2, 1'b1));
         trace.push_back(mk(3'd4, RW | RDST, 2'b00, 2'd0, 1'b1));
      end else if (is_addiu) begin
         trace.push_back(mk(3'd2, ASA, 2'b10, 2'd0, 1'b1));
         trace.push_back(mk(3'd4, RW, 2'b00, 2'd0, 1'b1));
      end else if (is_lw || is_sw) begin
         trace.push_back(mk(3'd2, ASA, 2'b10, 2'd0, 1'b1));
         c = IORD | (is_lw ? MRD : MWR);
         for (int i = 0; i < wm; i++) trace.push_back(mk(3'd3, c, 2'b00, 2'd0, 1'b0));
         trace.push_back(mk(3'd3, c, 2'b00, 2'd0, 1'b1));
         if (is_lw) trace.push_back(mk(3'd4, RW | MTR, 2'b00, 2'd0, 1'b1));
      end else if (is_br) begin
         trace.push_back(mk(3'd2, ASA | BR, 2'b00, 2'd1, 1'b1));
      end else begin
         legal = (bt == 5'b00000) || (bt == 5'b00001) || (bt == 5'b10000) || (bt == 5'b10001);
         c = ASA;
         if (legal) c = c | BR;
         if (legal && bt[4]) c = c | LNK | RW;
         trace.push_back(mk(3'd2, c, 2'b00, 2'd3, 1'b1));
      end
   endtask

   // Called at posedge+1; leaves at posedge+1 of the cycle after the last executed entry.
   task automatic run(input string nm, input logic [5:0] opc, input logic [4:0] bt,
                      input int wf, input int wm, input int cpi, input int stop_after);
      cur = nm;
      build(opc, bt, wf, wm, first_done);
      if (stop_after < 0) chk("cpi", 32'(trace.size() - wf - wm), 32'(cpi));
      for (int i = 0; i < trace.size(); i++) begin
         if (stop_after >= 0 && i == stop_after) break;
         if (trace[i].st <= 3'd1) begin
            bus.opcode      = opc;
            bus.branch_type = bt;
         end else begin
            bus.opcode      = 6'b111111;
            bus.branch_type = 5'b01010;
         end
         bus.mem_ready = trace[i].rdy;
         exp_c = trace[i];
         exp_v = 1'b1;
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      exp_v = 1'b0;
      first_done = (stop_after < 0);
   endtask

   task automatic reset_pulse(input string nm);
      cur = nm;
      exp_v = 1'b0;
      #1 rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      chk("rst_async_ctrl", 32'(ctrl_vec()), 32'd0);
      chk("rst_async_state", 32'(bus.state), 32'd0);
      chk("rst_async_alu", 32'({bus.aluop, bus.alusrc_b}), 32'd0);
      exp_c = mk(3'd0, 13'h0, 2'b00, 2'd0, 1'b0);
      exp_v = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      #1 rst_n = 1'b1;
      exp_v = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_state", 32'(bus.state), 32'd0);
      chk("post_rst_done", 32'(bus.instr_done), 32'd0);
      chk("post_rst_memread", 32'(bus.memread), 32'd1);
      chk("post_rst_memwrite", 32'(bus.memwrite), 32'd0);
      first_done = 1'b0;
   endtask

   // Per-cycle comparison against the expected trace entry plus always-true safety rules.
   always @(negedge clk) begin
      if (exp_v) begin
         chk("ctrl", 32'(ctrl_vec()), 32'(exp_c.c));
         chk("state", 32'(bus.state), 32'(exp_c.st));
         chk("alusrc_b", 32'(bus.alusrc_b), 32'(exp_c.b));
         chk("aluop", 32'(bus.aluop), 32'(exp_c.op));
         chk("rd_wr_excl", 32'(bus.memread & bus.memwrite), 32'd0);
         chk("rw_in_fetch_mem",
             32'(bus.regwrite & ((bus.state == 3'd0) | (bus.state == 3'd3))), 32'd0);
      end
   end

   initial begin
      rst_n           = 1'b0;
      bus.opcode      = '0;
      bus.branch_type = '0;
      bus.mem_ready   = 1'b0;
      first_done      = 1'b0;
      exp_v           = 1'b0;
      cur             = "reset";
      #2;
      chk("reset_state", 32'(bus.state), 32'd0);
      chk("reset_ctrl", 32'(ctrl_vec()), 32'd0);
      chk("reset_alu", 32'({bus.aluop, bus.alusrc_b}), 32'd0);
      @(posedge clk);
      #1;
      chk("reset_hold_ctrl", 32'(ctrl_vec()), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("first_fetch_done", 32'(bus.instr_done), 32'd0);
      chk("first_fetch_state", 32'(bus.state), 32'd0);

      run("addiu",     6'b001001, 5'b00000, 0, 0, 4, -1);
      run("lw_wait2",  6'b100011, 5'b00000, 0, 2, 5, -1);
      run("sw",        6'b101011, 5'b00000, 0, 1, 4, -1);
      run("jal",       6'b000011, 5'b00000, 0, 0, 2, -1);
      run("j_fwait",   6'b000010, 5'b00000, 2, 0, 2, -1);
      run("rtype",     6'b000000, 5'b00000, 1, 0, 4, -1);
      run("beq",       6'b000100, 5'b00000, 0, 0, 3, -1);
      run("bne",       6'b000101, 5'b10001, 0, 0, 3, -1);
      run("bgezal",    6'b000001, 5'b10001, 0, 0, 3, -1);
      run("bltz",      6'b000001, 5'b00000, 0, 0, 3, -1);
      run("regimm_ud", 6'b000001, 5'b00111, 0, 0, 3, -1);
      run("nop",       6'b111111, 5'b00000, 0, 0, 2, -1);
      run("lw_fast",   6'b100011, 5'b00000, 1, 0, 5, -1);

      run("abort_fetch", 6'b001001, 5'b00000, 3, 0, 4, 2);
      reset_pulse("rst_in_fetch_wait");
      run("abort_sw",    6'b101011, 5'b00000, 0, 3, 4, 4);
      chk("abort_sw_in_mem", 32'(bus.state), 32'd3);
      reset_pulse("rst_in_sw_mem");
      run("after_rst",   6'b100011, 5'b00000, 0, 1, 5, -1);
      run("tail_addiu",  6'b001001, 5'b00000, 0, 0, 4, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
